// File: rtl/hazard_pkg.sv
// Shared types for the multi-port hazard unit: writeback-source codes,
// MDU scoreboard states and a saturating increment for the perf counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    ALU_RES = 2'd0,
    PC_ADD4 = 2'd1,
    MEM_RD  = 2'd2,
    IMM     = 2'd3
  } wd_sel_e;

  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_BUSY  = 2'd1,
    MDU_WBREQ = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_fwd_mux.sv
// One EX read port: MEM/WB match detection, forwarded value select and
// load-use flag. MEM wins over WB; x0 never matches.
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_re,
  input  logic [4:0]      i_ra,
  input  logic [XLEN-1:0] i_rd_raw,
  input  logic            i_we_mem,
  input  logic [4:0]      i_wa_mem,
  input  logic [1:0]      i_wd_sel_mem,
  input  logic [XLEN-1:0] i_alu_ans_mem,
  input  logic [XLEN-1:0] i_pc_add4_mem,
  input  logic [XLEN-1:0] i_imm_mem,
  input  logic            i_we_wb,
  input  logic [4:0]      i_wa_wb,
  input  logic [XLEN-1:0] i_wd_wb,
  output logic            o_fe,
  output logic [XLEN-1:0] o_fd,
  output logic            o_lu
);

  logic            w_mem_hit, w_wb_hit;
  logic [XLEN-1:0] w_mem_val;

  assign w_mem_hit = i_re && i_we_mem && (i_wa_mem != 5'd0) && (i_wa_mem == i_ra);
  assign w_wb_hit  = i_re && i_we_wb  && (i_wa_wb  != 5'd0) && (i_wa_wb  == i_ra);
  assign o_lu      = w_mem_hit && (i_wd_sel_mem == MEM_RD);

  always_comb begin
    case (i_wd_sel_mem)
      PC_ADD4: w_mem_val = i_pc_add4_mem;
      IMM:     w_mem_val = i_imm_mem;
      default: w_mem_val = i_alu_ans_mem;
    endcase
  end

  // A load in MEM blocks the WB fallback: the stall retries next cycle.
  always_comb begin
    o_fe = 1'b0;
    o_fd = i_rd_raw;
    if (w_mem_hit) begin
      if (!o_lu) begin
        o_fe = 1'b1;
        o_fd = w_mem_val;
      end
    end else if (w_wb_hit) begin
      o_fe = 1'b1;
      o_fd = i_wd_wb;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: NRP-port forwarding, load-use, control flush and MDU scoreboard.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NRP     = 2,
  parameter int MDU_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*5-1:0]    rf_ra_ex,
  input  logic [NRP-1:0]      rf_re_ex,
  input  logic [NRP*XLEN-1:0] rf_rd_ex,
  input  logic                rf_we_mem,
  input  logic [4:0]          rf_wa_mem,
  input  logic [1:0]          rf_wd_sel_mem,
  input  logic [XLEN-1:0]     alu_ans_mem,
  input  logic [XLEN-1:0]     pc_add4_mem,
  input  logic [XLEN-1:0]     imm_mem,
  input  logic                rf_we_wb,
  input  logic [4:0]          rf_wa_wb,
  input  logic [XLEN-1:0]     rf_wd_wb,
  input  logic                mdu_start_ex,
  input  logic [4:0]          mdu_wa_ex,
  input  logic                jal_ex,
  input  logic                jalr_ex,
  input  logic                br_ex,
  output logic [NRP-1:0]      rf_rd_fe,
  output logic [NRP*XLEN-1:0] rf_rd_fd,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                flush_mem,
  output logic                mdu_busy,
  output logic                mdu_wb_req
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_lu_cnt,
  output logic [31:0]         perf_mdu_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  logic [NRP-1:0][4:0]      w_ra;
  logic [NRP-1:0][XLEN-1:0] w_rd, w_fd;
  logic [NRP-1:0]           w_lu_p, w_raw_p;
  logic w_lu, w_busy, w_wbreq, w_waw, w_mdu_stall, w_stall, w_redir;

  mdu_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]    r_wa, w_wa_nxt;

  assign w_ra     = rf_ra_ex;
  assign w_rd     = rf_rd_ex;
  assign rf_rd_fd = w_fd;

  for (genvar g = 0; g < NRP; g++) begin : g_port
    fwd_mux #(.XLEN(XLEN)) u_fwd (
      .i_re          (rf_re_ex[g]),
      .i_ra          (w_ra[g]),
      .i_rd_raw      (w_rd[g]),
      .i_we_mem      (rf_we_mem),
      .i_wa_mem      (rf_wa_mem),
      .i_wd_sel_mem  (rf_wd_sel_mem),
      .i_alu_ans_mem (alu_ans_mem),
      .i_pc_add4_mem (pc_add4_mem),
      .i_imm_mem     (imm_mem),
      .i_we_wb       (rf_we_wb),
      .i_wa_wb       (rf_wa_wb),
      .i_wd_wb       (rf_wd_wb),
      .o_fe          (rf_rd_fe[g]),
      .o_fd          (w_fd[g]),
      .o_lu          (w_lu_p[g])
    );
    assign w_raw_p[g] = rf_re_ex[g] && (w_ra[g] != 5'd0) && (w_ra[g] == r_wa);
  end

  assign w_busy  = (r_state != MDU_IDLE);
  assign w_wbreq = (r_state == MDU_WBREQ);
  assign w_lu    = |w_lu_p;
  assign w_waw   = mdu_start_ex && (mdu_wa_ex == r_wa);

  // Load-use and MDU stalls share one bubble; WBREQ itself stalls to free WB.
  assign w_mdu_stall = w_busy && ((|w_raw_p) || w_waw || mdu_start_ex || w_wbreq);
  assign w_stall     = w_lu || w_mdu_stall;
  assign w_redir     = (jal_ex || jalr_ex || br_ex) && !w_stall;

  assign stall_if   = w_stall;
  assign stall_id   = w_stall;
  assign stall_ex   = w_stall;
  assign flush_mem  = w_stall;
  assign flush_id   = w_redir;
  assign flush_ex   = w_redir;
  assign mdu_busy   = w_busy;
  assign mdu_wb_req = w_wbreq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_wa    <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wa    <= w_wa_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wa_nxt    = r_wa;
    case (r_state)
      MDU_IDLE: if (mdu_start_ex && !w_stall) begin
        w_state_nxt = MDU_BUSY;
        w_cnt_nxt   = CW'(MDU_LAT - 1);
        w_wa_nxt    = mdu_wa_ex;
      end
      MDU_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = MDU_WBREQ;
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt    <= 32'd0;
      perf_mdu_cnt   <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (w_lu)        perf_lu_cnt    <= sat_inc(perf_lu_cnt);
      if (w_mdu_stall) perf_mdu_cnt   <= sat_inc(perf_mdu_cnt);
      if (w_redir)     perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomized + directed bench for hazard_unit_mc against a cycle-indexed
// behavioural model (MDU tracked as "issued at cycle c, writeback at c+LAT").
module tb_hazard_unit_mc;

  localparam int XLEN = 32, NRP = 2, MDU_LAT = 4;

  logic clk = 1'b0, rst;
  logic [NRP*5-1:0]    rf_ra_ex;
  logic [NRP-1:0]      rf_re_ex;
  logic [NRP*XLEN-1:0] rf_rd_ex;
  logic                rf_we_mem, rf_we_wb, mdu_start_ex, jal_ex, jalr_ex, br_ex;
  logic [4:0]          rf_wa_mem, rf_wa_wb, mdu_wa_ex;
  logic [1:0]          rf_wd_sel_mem;
  logic [XLEN-1:0]     alu_ans_mem, pc_add4_mem, imm_mem, rf_wd_wb;
  logic [NRP-1:0]      rf_rd_fe;
  logic [NRP*XLEN-1:0] rf_rd_fd;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_busy, mdu_wb_req;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt;
`endif

  hazard_unit_mc #(.XLEN(XLEN), .NRP(NRP), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst(rst),
    .rf_ra_ex(rf_ra_ex), .rf_re_ex(rf_re_ex), .rf_rd_ex(rf_rd_ex),
    .rf_we_mem(rf_we_mem), .rf_wa_mem(rf_wa_mem), .rf_wd_sel_mem(rf_wd_sel_mem),
    .alu_ans_mem(alu_ans_mem), .pc_add4_mem(pc_add4_mem), .imm_mem(imm_mem),
    .rf_we_wb(rf_we_wb), .rf_wa_wb(rf_wa_wb), .rf_wd_wb(rf_wd_wb),
    .mdu_start_ex(mdu_start_ex), .mdu_wa_ex(mdu_wa_ex),
    .jal_ex(jal_ex), .jalr_ex(jalr_ex), .br_ex(br_ex),
    .rf_rd_fe(rf_rd_fe), .rf_rd_fd(rf_rd_fd),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .mdu_busy(mdu_busy), .mdu_wb_req(mdu_wb_req)
`ifdef HAZARD_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_mdu_cnt(perf_mdu_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: MDU in flight means "issued at some cycle, writes back at m_wb_at".
  int   cyc_n = 0;
  bit   m_busy, n_busy;
  int   m_wb_at, n_wb_at;
  logic [4:0] m_wa, n_wa;
  int   m_lu, m_mdu, m_fl, n_lu, n_mdu, n_fl;

  task automatic model_reset();
    m_busy = 0; m_wb_at = 0; m_wa = 5'd0;
    m_lu = 0; m_mdu = 0; m_fl = 0;
  endtask

  task automatic eval_and_check();
    logic [NRP-1:0]  efe, lu_p;
    logic [XLEN-1:0] efd;
    logic [4:0]      ra;
    bit lu, raw, wbreq, mstall, stall, redir;
    wbreq = m_busy && (cyc_n == m_wb_at);
    lu = 0; raw = 0; efe = '0; lu_p = '0;
    for (int i = 0; i < NRP; i++) begin
      ra  = rf_ra_ex[5*i +: 5];
      efd = rf_rd_ex[XLEN*i +: XLEN];
      if (rf_re_ex[i] && rf_we_mem && rf_wa_mem != 0 && rf_wa_mem == ra) begin
        if (rf_wd_sel_mem == 2'd2) begin lu_p[i] = 1; lu = 1; end
        else begin
          efe[i] = 1;
          efd = (rf_wd_sel_mem == 2'd0) ? alu_ans_mem :
                (rf_wd_sel_mem == 2'd1) ? pc_add4_mem : imm_mem;
        end
      end else if (rf_re_ex[i] && rf_we_wb && rf_wa_wb != 0 && rf_wa_wb == ra) begin
        efe[i] = 1; efd = rf_wd_wb;
      end
      if (!lu_p[i]) chk($sformatf("fd%0d", i), rf_rd_fd[XLEN*i +: XLEN], efd);
      if (m_busy && rf_re_ex[i] && ra != 0 && ra == m_wa) raw = 1;
    end
    mstall = m_busy && (raw || mdu_start_ex || wbreq);
    stall  = lu || mstall;
    redir  = (jal_ex || jalr_ex || br_ex) && !stall;
    chk("fe", rf_rd_fe, efe);
    chk("ctl", {stall_if, stall_id, stall_ex, flush_mem, flush_id, flush_ex},
               {stall, stall, stall, stall, redir, redir});
    chk("busy", mdu_busy, m_busy);
    chk("wbreq", mdu_wb_req, wbreq);
`ifdef HAZARD_PERF_EN
    chk("perf_lu", perf_lu_cnt, m_lu);
    chk("perf_mdu", perf_mdu_cnt, m_mdu);
    chk("perf_fl", perf_flush_cnt, m_fl);
`endif
    n_busy = m_busy; n_wb_at = m_wb_at; n_wa = m_wa;
    n_lu = m_lu + int'(lu); n_mdu = m_mdu + int'(mstall); n_fl = m_fl + int'(redir);
    if (wbreq) n_busy = 0;
    else if (!m_busy && mdu_start_ex && !stall) begin
      n_busy = 1; n_wb_at = cyc_n + MDU_LAT; n_wa = mdu_wa_ex;
    end
  endtask

  // Inputs are set after posedge+1; check at negedge; advance model at posedge.
  task automatic step();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_busy = n_busy; m_wb_at = n_wb_at; m_wa = n_wa;
      m_lu = n_lu; m_mdu = n_mdu; m_fl = n_fl;
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle_inputs();
    rf_ra_ex = '0; rf_re_ex = '0; rf_rd_ex = '0;
    rf_we_mem = 0; rf_wa_mem = 0; rf_wd_sel_mem = 0;
    alu_ans_mem = 0; pc_add4_mem = 0; imm_mem = 0;
    rf_we_wb = 0; rf_wa_wb = 0; rf_wd_wb = 0;
    mdu_start_ex = 0; mdu_wa_ex = 0; jal_ex = 0; jalr_ex = 0; br_ex = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_busy", mdu_busy, 1'b0);
    chk("rst_ctl", {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_wb_req}, 7'd0);
    step();
    rst = 1'b0;
    step();

    // MEM priority over WB
    rf_we_mem = 1; rf_wa_mem = 5; alu_ans_mem = 32'h11;
    rf_we_wb = 1; rf_wa_wb = 5; rf_wd_wb = 32'h22;
    rf_ra_ex[4:0] = 5; rf_re_ex = 2'b01; rf_rd_ex = 64'h0000_0033_0000_0044;
    #2;
    chk("t1_fd0", rf_rd_fd[31:0], 32'h11);
    chk("t1_fe0", rf_rd_fe[0], 1'b1);
    chk("t1_stall", stall_ex, 1'b0);
    step();

    // load-use on port 1, then WB forwards the load data
    idle_inputs();
    rf_we_mem = 1; rf_wa_mem = 7; rf_wd_sel_mem = 2'd2;
    rf_ra_ex[9:5] = 7; rf_re_ex = 2'b10;
    #2;
    chk("t2_lu", {stall_if, stall_id, stall_ex, flush_mem, rf_rd_fe[1]}, 5'b11110);
    step();
    idle_inputs();
    rf_we_wb = 1; rf_wa_wb = 7; rf_wd_wb = 32'hDEAD_BEEF;
    rf_ra_ex[9:5] = 7; rf_re_ex = 2'b10;
    #2;
    chk("t2_wb", {stall_ex, rf_rd_fe[1]}, 2'b01);
    chk("t2_fd1", rf_rd_fd[63:32], 32'hDEAD_BEEF);
    step();

    // x0 never forwarded
    idle_inputs();
    rf_we_mem = 1; rf_wa_mem = 0; alu_ans_mem = 32'hFF; rf_re_ex = 2'b01;
    #2;
    chk("t3_x0", {rf_rd_fe[0], rf_rd_fd[31:0]}, 33'd0);
    step();

    // MDU issue to x9, independent traffic, wb_req after MDU_LAT cycles
    idle_inputs();
    mdu_start_ex = 1; mdu_wa_ex = 9;
    step();
    mdu_start_ex = 0; rf_ra_ex[4:0] = 3; rf_re_ex = 2'b01;
    for (int k = 1; k < MDU_LAT; k++) begin
      #2; chk("t4_nostall", stall_ex, 1'b0);
      step();
    end
    #2; chk("t4_wbreq", {mdu_wb_req, stall_ex}, 2'b11);
    step();
    // RAW on x9 stalls until the WBREQ cycle is done
    mdu_start_ex = 1; mdu_wa_ex = 9; rf_re_ex = 2'b00;
    step();
    mdu_start_ex = 0; rf_ra_ex[4:0] = 9; rf_re_ex = 2'b01;
    for (int k = 0; k < MDU_LAT; k++) begin
      #2; chk("t4_raw", stall_ex, 1'b1);
      step();
    end
    #2; chk("t4_after", {stall_ex, mdu_busy}, 2'b00);
    step();

    // redirect suppressed under load-use, honoured next cycle
    idle_inputs();
    rf_we_mem = 1; rf_wa_mem = 4; rf_wd_sel_mem = 2'd2;
    rf_ra_ex[4:0] = 4; rf_re_ex = 2'b01; br_ex = 1;
    #2; chk("t5_sup", {flush_id, flush_ex}, 2'b00);
    step();
    rf_we_mem = 0;
    #2; chk("t5_fl", {flush_id, flush_ex}, 2'b11);
    step();

    // reset mid-operation abandons the MDU op
    idle_inputs();
    mdu_start_ex = 1; mdu_wa_ex = 12;
    step();
    mdu_start_ex = 0;
    step();
    rst = 1'b1;
    model_reset();
    #1; chk("t6_busy", mdu_busy, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < MDU_LAT + 2; k++) step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRP; i++) begin
        rf_ra_ex[5*i +: 5] = 5'($urandom_range(0, 3));
        rf_rd_ex[XLEN*i +: XLEN] = $urandom;
      end
      rf_re_ex = NRP'($urandom);
      rf_we_mem = 1'($urandom); rf_wa_mem = 5'($urandom_range(0, 3));
      rf_wd_sel_mem = 2'($urandom);
      alu_ans_mem = $urandom; pc_add4_mem = $urandom; imm_mem = $urandom;
      rf_we_wb = 1'($urandom); rf_wa_wb = 5'($urandom_range(0, 3)); rf_wd_wb = $urandom;
      mdu_start_ex = ($urandom_range(0, 3) == 0); mdu_wa_ex = 5'($urandom_range(0, 3));
      jal_ex = ($urandom_range(0, 7) == 0);
      jalr_ex = ($urandom_range(0, 7) == 0);
      br_ex = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised successor to the pipeline hazard unit. It resolves EX-stage operand hazards by forwarding from MEM and WB across NRP read ports, and detects load-use hazards. It also handles control hazards and adds a non-blocking multi-cycle unit (MDU) scoreboard with an internal latency counter. The unit sits beside the 5-stage pipeline, drives stall/flush controls and operand muxes, and schedules the MDU's writeback slot.

Parameters:
XLEN, 32, datapath width
NRP, 2, number of EX register read ports
MDU_LAT, 4, MDU cycles from issue to result ready (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rf_ra_ex  in  NRP*5  packed EX read addresses, port i at [5i+4:5i]
rf_re_ex  in  NRP  EX read enables
rf_rd_ex  in  NRP*XLEN  raw register-file data in EX
rf_we_mem / rf_wa_mem  in  1 / 5  MEM write enable / address
rf_wd_sel_mem  in  2  MEM writeback source: 00 ALU, 01 PC+4, 10 MEM_RD, 11 IMM
alu_ans_mem / pc_add4_mem / imm_mem  in  XLEN  MEM candidate results
rf_we_wb / rf_wa_wb / rf_wd_wb  in  1 / 5 / XLEN  WB write port
mdu_start_ex / mdu_wa_ex  in  1 / 5  EX holds an MDU op writing mdu_wa_ex
jal_ex, jalr_ex, br_ex  in  1 each  taken redirect in EX
rf_rd_fe  out  NRP  per-port "forwarded" flag
rf_rd_fd  out  NRP*XLEN  final EX operands (forwarded or raw)
stall_if, stall_id, stall_ex  out  1 each
flush_id, flush_ex, flush_mem  out  1 each
mdu_busy  out  1  MDU op in flight
mdu_wb_req  out  1  one-cycle pulse: MDU result owns WB next cycle

Behaviour:
- Reset (async): FSM to IDLE, counter=0, mdu_wa_q=0. mdu_busy=0, mdu_wb_req=0, all stall/flush=0.
- Forwarding, per port i, combinational:
  - Source is MEM if rf_re_ex[i], rf_we_mem, rf_wa_mem!=0 and rf_wa_mem==ra_i; value is ALU/PC+4/IMM per sel.
  - Otherwise source is WB under the same conditions, value rf_wd_wb.
  - Otherwise rf_rd_ex[i], with fe=0.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use: a MEM match with sel=MEM_RD sets stall_if/id/ex=1 and flush_mem=1 for that cycle; fe[i]=0 for that port.
- MDU FSM, IDLE -> BUSY -> WBREQ -> IDLE:
  - IDLE: on mdu_start_ex and no stall, latch mdu_wa_q, counter=MDU_LAT-1, go BUSY.
  - BUSY: decrement counter; at 0 go WBREQ.
  - WBREQ: mdu_wb_req=1, stall_if/id/ex=1, flush_mem=1 (frees the WB slot), then IDLE.
  - mdu_busy=1 in BUSY and WBREQ.
- MDU hazards while busy, each giving stall_if/id/ex=1 and flush_mem=1:
  - RAW: EX reads a nonzero register == mdu_wa_q.
  - WAW: EX writes mdu_wa_q.
  - Structural: a new mdu_start_ex arrives.
- Control: flush_id=flush_ex=1 when (jal|jalr|br)_ex and stall_ex=0. Redirects are ignored while EX is stalled; they are re-evaluated next cycle with correct operands.
- Simultaneous load-use and MDU stall: one merged stall, with no double bubble per cycle.
- Reset mid-operation: the in-flight MDU op is abandoned and no mdu_wb_req is issued.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt (32 b each). They count cycles of load-use stall, MDU stall and redirect flush. Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg: WD_SEL codes (ALU_RES=0, PC_ADD4=1, MEM_RD=2, IMM=3) and MDU FSM state encoding.
- Sub-module fwd_mux: one instance per read port, generated over NRP. It does match detection and value select, and outputs fe, fd and a load-use flag.

Test Plan:
- MEM ALU 0x11 to x5, WB 0x22 to x5, EX reads x5 on port 0 -> fd0=0x11, fe0=1, no stall.
- Load to x7 in MEM, EX reads x7 on port 1 -> one cycle of stall_if/id/ex=1 and flush_mem=1; next cycle WB forwards the load data.
- EX reads x0 while MEM writes x0 value 0xFF -> fe=0, fd=raw 0.
- MDU issue to x9 with MDU_LAT=4, independent ops follow -> no stall; mdu_wb_req pulses 4 cycles after issue with a bubble; a read of x9 before then stalls until WBREQ completes.
- br_ex=1 during load-use stall -> flush_id/ex=0 that cycle, =1 the next cycle.
- rst asserted while BUSY -> mdu_busy=0 immediately, no mdu_wb_req thereafter.
